rmt_stage_shell: RTL and testbench

RMT_STAGE_SHELL -- requirements
Module: rmt_stage_shell

---
 rtl/rmt_stage_shell.sv | 131 +++++++++++++
 tb/tb_rmt_stage_shell.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_stage_shell.sv
// RMT stage shell: issues PHVs to an external fixed-latency match-action datapath or
// bypasses it, and delivers results downstream in acceptance order through a FWFT FIFO.
module rmt_stage_shell #(
    parameter int PHV_LEN    = 1124,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               axis_clk,
    input  logic               areset,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_in_valid,
    output logic               phv_in_ready,
    output logic [PHV_LEN-1:0] proc_phv_out,
    output logic               proc_phv_out_valid,
    input  logic [PHV_LEN-1:0] proc_phv_in,
    input  logic               proc_phv_in_valid,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_out_valid,
    input  logic               phv_out_ready,
    input  logic               stage_en,
    output logic [31:0]        stat_pkt_cnt,
    output logic               stat_proto_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    inflight_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PHV_LEN-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PIPE_LAT-1:0] issue_sr;

    logic               accept;
    logic               issue;
    logic               ret_ok;
    logic               ret_drop;
    logic               ret_mismatch;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     credit_used;
    logic [PHV_LEN-1:0] push_data;

    // Every FIFO slot is pre-reserved at accept time, so a return can never meet a full FIFO.
    assign credit_used  = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
    assign phv_in_ready = !areset && (credit_used < CREDIT_MAX)
                          && (stage_en || (inflight_cnt == '0));

    assign accept        = phv_in_valid && phv_in_ready;
    assign issue         = accept && stage_en;
    assign ret_ok        = proc_phv_in_valid && (inflight_cnt != '0);
    assign ret_drop      = proc_phv_in_valid && (inflight_cnt == '0);
    assign ret_mismatch  = proc_phv_in_valid != issue_sr[PIPE_LAT-1];
    assign phv_out_valid = (fifo_cnt != '0);
    assign phv_out       = fifo_mem[rd_ptr];
    assign pop           = phv_out_valid && phv_out_ready;

    // A bypass needs inflight_cnt==0 while a usable return needs inflight_cnt!=0,
    // so at most one source pushes in any cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push      = 1'b0;
        push_data = phv_in;
        if (ret_ok) begin
            push      = 1'b1;
            push_data = proc_phv_in;
        end else if (accept && !stage_en) begin
            push = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            proc_phv_out_valid <= 1'b0;
            issue_sr           <= '0;
            inflight_cnt       <= '0;
            fifo_cnt           <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            stat_pkt_cnt       <= '0;
            stat_proto_err     <= 1'b0;
        end else begin
            proc_phv_out_valid <= issue;

            issue_sr[0] <= proc_phv_out_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                issue_sr[i] <= issue_sr[i-1];
            end

            if (issue && !ret_ok) begin
                inflight_cnt <= inflight_cnt + CNT_ONE;
            end else if (!issue && ret_ok) begin
                inflight_cnt <= inflight_cnt - CNT_ONE;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_ONE;
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end

            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_ONE;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CNT_ONE;
            end

            if (ret_mismatch || ret_drop) begin
                stat_proto_err <= 1'b1;
            end
        end
    end

    // NOTE: payload storage has no reset; the valid flags and fifo_cnt qualify it.
    always_ff @(posedge axis_clk) begin
        if (issue) begin
            proc_phv_out <= phv_in;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_rmt_stage_shell.sv
// Scoreboard bench for rmt_stage_shell: a loopback datapath model feeds returns back, and a
// monitor compares every delivered PHV against the acceptance-order queue.
module tb_rmt_stage_shell;

    localparam int PHV_LEN    = 96;
    localparam int PIPE_LAT   = 4;
    localparam int FIFO_DEPTH = 8;

    typedef logic [PHV_LEN-1:0] phv_t;
    typedef struct {
        int   due;
        phv_t data;
    } ret_t;

    logic         axis_clk = 1'b0;
    logic         areset = 1'b1;
    phv_t         phv_in = '0;
    logic         phv_in_valid = 1'b0;
    logic         phv_in_ready;
    phv_t         proc_phv_out;
    logic         proc_phv_out_valid;
    phv_t         proc_phv_in = '0;
    logic         proc_phv_in_valid = 1'b0;
    phv_t         phv_out;
    logic         phv_out_valid;
    logic         phv_out_ready = 1'b1;
    logic         stage_en = 1'b0;
    logic [31:0]  stat_pkt_cnt;
    logic         stat_proto_err;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    phv_t exp_q[$];
    ret_t pend[$];
    int   extra_delay = 0;
    bit   inject_unsol = 1'b0;
    int   model_pkt = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    rmt_stage_shell #(
        .PHV_LEN   (PHV_LEN),
        .PIPE_LAT  (PIPE_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .axis_clk          (axis_clk),
        .areset            (areset),
        .phv_in            (phv_in),
        .phv_in_valid      (phv_in_valid),
        .phv_in_ready      (phv_in_ready),
        .proc_phv_out      (proc_phv_out),
        .proc_phv_out_valid(proc_phv_out_valid),
        .proc_phv_in       (proc_phv_in),
        .proc_phv_in_valid (proc_phv_in_valid),
        .phv_out           (phv_out),
        .phv_out_valid     (phv_out_valid),
        .phv_out_ready     (phv_out_ready),
        .stage_en          (stage_en),
        .stat_pkt_cnt      (stat_pkt_cnt),
        .stat_proto_err    (stat_proto_err)
    );

    initial forever #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic phv_t rand_phv();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #2;
    endtask

    // Offer one PHV until accepted; records the accept cycle and the expected output.
    task automatic send(input phv_t d, input logic en, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        phv_in = d;
        stage_en = en;
        phv_in_valid = 1'b1;
        while (acc_cyc < 0 && n < 200) begin
            @(negedge axis_clk);
            if (phv_in_ready) begin
                acc_cyc = cyc;
                exp_q.push_back(d);
            end
            tick();
            n++;
        end
        phv_in_valid = 1'b0;
        if (acc_cyc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Datapath model: each issued PHV comes back unchanged PIPE_LAT cycles later.
    initial begin : datapath_model
        ret_t r;
        forever begin
            @(posedge axis_clk);
            #1;
            proc_phv_in_valid = 1'b0;
            if (areset) pend.delete();
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                proc_phv_in = r.data;
                proc_phv_in_valid = 1'b1;
            end else if (inject_unsol) begin
                proc_phv_in = rand_phv();
                proc_phv_in_valid = 1'b1;
                inject_unsol = 1'b0;
            end
            if (proc_phv_out_valid) begin
                r.due = cyc + PIPE_LAT + extra_delay;
                r.data = proc_phv_out;
                extra_delay = 0;
                pend.push_back(r);
            end
        end
    end

    initial begin : monitor
        phv_t e;
        forever begin
            @(negedge axis_clk);
            if (!areset && phv_out_valid && phv_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("phv_out_data", phv_out, e);
                end
                model_pkt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    initial begin : stimulus
        int   t_acc, t_pov, t_out, acc, pkt0, n, sent, c0;
        int   a1, a2, a3, a4;
        phv_t d;

        // Reset state
        repeat (3) tick();
        @(negedge axis_clk);
        check("rst_in_ready", phv_in_ready, 0);
        check("rst_proc_valid", proc_phv_out_valid, 0);
        check("rst_out_valid", phv_out_valid, 0);
        check("rst_pkt_cnt", stat_pkt_cnt, 0);
        check("rst_proto_err", stat_proto_err, 0);
        tick();
        areset = 1'b0;
        @(negedge axis_clk);
        check("ready_after_reset", phv_in_ready, 1);

        // Latency with a single PHV through the datapath
        tick();
        send(phv_t'(8'hA5), 1'b1, t_acc);
        t_pov = -1;
        t_out = -1;
        n = 0;
        while (t_out < 0 && n < 20) begin
            @(negedge axis_clk);
            if (proc_phv_out_valid && t_pov < 0) t_pov = cyc;
            if (phv_out_valid) t_out = cyc;
            tick();
            n++;
        end
        check("lat_issue", t_pov, t_acc + 1);
        check("lat_out", t_out, t_acc + 2 + PIPE_LAT);
        drain(50);
        check("lat_pkt_cnt", stat_pkt_cnt, 1);

        // Backpressure: credits cap acceptance at FIFO_DEPTH
        phv_out_ready = 1'b0;
        stage_en = 1'b1;
        acc = 0;
        d = rand_phv();
        phv_in = d;
        phv_in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge axis_clk);
            if (phv_in_ready) begin
                exp_q.push_back(d);
                acc++;
                d = rand_phv();
            end
            tick();
            phv_in = d;
        end
        phv_in_valid = 1'b0;
        check("bp_accepts", acc, FIFO_DEPTH);
        @(negedge axis_clk);
        check("bp_ready_low", phv_in_ready, 0);
        pkt0 = model_pkt;
        tick();
        phv_out_ready = 1'b1;
        drain(100);
        check("bp_pops", model_pkt - pkt0, FIFO_DEPTH);
        check("bp_no_err", stat_proto_err, 0);
        check("bp_pkt_cnt", stat_pkt_cnt, model_pkt);

        // Mode switch: bypass waits for the last in-flight PHV to return
        send(rand_phv(), 1'b1, a1);
        send(rand_phv(), 1'b1, a2);
        send(rand_phv(), 1'b1, a3);
        send(rand_phv(), 1'b0, a4);
        check("mode_consecutive", a3 - a1, 2);
        check("mode_bypass_wait", a4, a3 + PIPE_LAT + 2);
        drain(50);

        // Protocol errors: a late return, then an unsolicited one
        check("pe_clean", stat_proto_err, 0);
        extra_delay = 1;
        send(rand_phv(), 1'b1, acc);
        drain(50);
        check("pe_late_flag", stat_proto_err, 1);
        repeat (5) tick();
        check("pe_sticky", stat_proto_err, 1);
        pkt0 = model_pkt;
        n = 0;
        inject_unsol = 1'b1;
        repeat (6) begin
            @(negedge axis_clk);
            if (phv_out_valid) n++;
            tick();
        end
        check("pe_unsol_dropped", n, 0);
        check("pe_unsol_pkt_cnt", stat_pkt_cnt, pkt0);
        check("pe_still_set", stat_proto_err, 1);

        // Reset with 3 PHVs in flight and 2 queued
        phv_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(rand_phv(), 1'b1, acc);
        tick();
        tick();
        areset = 1'b1;
        exp_q.delete();
        model_pkt = 0;
        @(negedge axis_clk);
        check("mid_queued_before_rst", phv_out_valid, 1);
        tick();
        areset = 1'b0;
        @(negedge axis_clk);
        check("mid_ready", phv_in_ready, 1);
        check("mid_proc_valid", proc_phv_out_valid, 0);
        check("mid_out_valid", phv_out_valid, 0);
        check("mid_pkt_cnt", stat_pkt_cnt, 0);
        check("mid_proto_err", stat_proto_err, 0);

        // Bypass after reset: accepted at once, visible one cycle later
        phv_out_ready = 1'b1;
        tick();
        c0 = cyc;
        send(rand_phv(), 1'b0, acc);
        check("byp_immediate", acc, c0);
        @(negedge axis_clk);
        check("byp_lat_valid", phv_out_valid, 1);
        drain(20);
        repeat (8) tick();
        check("byp_pkt_cnt", stat_pkt_cnt, 1);
        check("byp_no_stale_err", stat_proto_err, 0);

        // Throughput: 1000 PHVs, one per cycle, no output bubbles
        stage_en = 1'b1;
        pkt0 = model_pkt;
        first_pop = -1;
        last_pop = -1;
        sent = 0;
        n = 0;
        d = rand_phv();
        phv_in = d;
        phv_in_valid = 1'b1;
        while (sent < 1000 && n < 5000) begin
            @(negedge axis_clk);
            if (phv_in_ready) begin
                exp_q.push_back(d);
                sent++;
                d = rand_phv();
            end
            tick();
            phv_in = d;
            n++;
        end
        phv_in_valid = 1'b0;
        drain(100);
        check("tp_sent", sent, 1000);
        check("tp_outputs", model_pkt - pkt0, 1000);
        check("tp_no_bubbles", last_pop - first_pop, 999);
        check("tp_pkt_cnt", stat_pkt_cnt, model_pkt);

        // Random mix of valid, mode and downstream backpressure
        for (int i = 0; i < 400; i++) begin
            d = rand_phv();
            phv_in = d;
            phv_in_valid = ($urandom_range(3) != 0);
            stage_en = $urandom_range(1);
            phv_out_ready = ($urandom_range(2) != 0);
            @(negedge axis_clk);
            if (phv_in_valid && phv_in_ready) exp_q.push_back(d);
            tick();
        end
        phv_in_valid = 1'b0;
        phv_out_ready = 1'b1;
        drain(200);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_pkt_cnt", stat_pkt_cnt, model_pkt);
        check("rnd_no_err", stat_proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
